// File: rtl/alu_exec_seq.sv
// Sequential ALU execution unit with valid/ready handshakes and iterative shifter.
// Optional macro ALU_FAST_SHIFT_EN: shift up to 4 bits per SHIFT cycle.
module alu_exec_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         operation,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               branch_taken,
  output logic               busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b0100;
  localparam logic [3:0] OP_BLT  = 4'b0101;
  localparam logic [3:0] OP_BGE  = 4'b0110;
  localparam logic [3:0] OP_JALR = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 branch_q, branch_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [3:0]           op_q, op_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_br;
  logic                 a_lt_b;
  logic [WIDTH-1:0]     sum;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   shamt;
  logic [SHAMT_W:0]     step;
  logic [WIDTH-1:0]     acc_next;
  logic [SHAMT_W-1:0]   count_next;

  // Single-cycle operations; shifts reach here only with a zero amount.
  always_comb begin
    a_lt_b   = $signed(src_a) < $signed(src_b);
    sum      = src_a + src_b;
    shamt    = src_b[SHAMT_W-1:0];
    is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);
    alu_res  = '0;
    alu_br   = 1'b0;
    case (operation)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res = src_a;
      OP_BEQ:  alu_br  = (src_a == src_b);
      OP_BNE:  alu_br  = (src_a != src_b);
      OP_BLT:  alu_br  = a_lt_b;
      OP_BGE:  alu_br  = !a_lt_b;
      OP_JALR: alu_res = sum & ~{{(WIDTH-1){1'b0}}, 1'b1};
      default: begin
        alu_res = '0;
        alu_br  = 1'b0;
      end
    endcase
  end

  always_comb begin
`ifdef ALU_FAST_SHIFT_EN
    step = ({1'b0, count_q} > (SHAMT_W+1)'(3)) ? (SHAMT_W+1)'(4) : {1'b0, count_q};
`else
    step = (SHAMT_W+1)'(1);
`endif
    case (op_q)
      OP_SLL:  acc_next = acc_q << step;
      OP_SRA:  acc_next = $signed(acc_q) >>> step;
      default: acc_next = acc_q >> step;
    endcase
    count_next = count_q - step[SHAMT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    acc_d    = acc_q;
    count_d  = count_q;
    op_d     = op_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = operation;
          if (is_shift && (shamt != '0)) begin
            acc_d   = src_a;
            count_d = shamt;
            state_d = S_SHIFT;
          end else begin
            result_d = alu_res;
            branch_d = alu_br;
            state_d  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        acc_d   = acc_next;
        count_d = count_next;
        if (count_next == '0) begin
          result_d = acc_next;
          branch_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q == S_SHIFT);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed vector table, corner sequences, random ops.
module tb_alu_exec_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_shift_op(input logic [3:0] op);
    return (op == 4'b1100) || (op == 4'b1011) || (op == 4'b1010);
  endfunction

  // Reference model: {branch, result} from the operation rules.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    int unsigned sh;
    logic [31:0] r;
    logic br;
    sa = a; sb = b; sh = int'(b[4:0]);
    r = 32'h0; br = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a ^ b;
      4'b0011: r = a + b;
      4'b1001: r = a - b;
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = a << sh;
      4'b1011: r = a >> sh;
      4'b1010: r = 32'(sa >>> sh);
      4'b1000: br = (a == b);
      4'b0100: br = (a != b);
      4'b0101: br = (sa < sb);
      4'b0110: br = (sa >= sb);
      4'b1101: r = (a + b) & 32'hFFFF_FFFE;
      default: begin r = 32'h0; br = 1'b0; end
    endcase
    return {br, r};
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (!is_shift_op(op) || sh == 0) return 1;
`ifdef ALU_FAST_SHIFT_EN
    return (sh + 3) / 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  // Issue one op at a negedge, measure latency/busy, hold for `hold` cycles, then handshake.
  task automatic exec(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int hold, input bit pulse,
                      input logic [31:0] exp_res, input logic exp_br);
    int lat, bz, exp_lat;
    exp_lat = model_lat(op, b);
    chk({name, " in_ready_before"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; operation = op; src_a = a; src_b = b; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; operation = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1; bz = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bz++;
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " busy_cycles"}, 32'(bz), 32'(exp_lat - 1));
    chk({name, " result"}, result, exp_res);
    chk({name, " branch"}, {31'b0, branch_taken}, {31'b0, exp_br});
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse && (i % 2 == 0);
      @(negedge clk);
      chk({name, " hold_result"}, result, exp_res);
      chk({name, " hold_valid"}, {31'b0, out_valid}, 32'd1);
      if (pulse) chk({name, " hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({name, " out_valid_after"}, {31'b0, out_valid}, 32'd0);
    chk({name, " in_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [32:0] m;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    tbl[0]  = '{4'b0011, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0};
    tbl[1]  = '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    tbl[2]  = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[3]  = '{4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[4]  = '{4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1};
    tbl[5]  = '{4'b0100, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0};
    tbl[6]  = '{4'b1100, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0};
    tbl[7]  = '{4'b1111, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0};
    tbl[8]  = '{4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[9]  = '{4'b1001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
    tbl[10] = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[11] = '{4'b1101, 32'h0000_1001, 32'h0000_0010, 32'h0000_1010, 1'b0};
    tbl[12] = '{4'b1011, 32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 1'b0};
    tbl[13] = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    tbl[14] = '{4'b0001, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, 1'b0};
    tbl[15] = '{4'b0010, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0};

    reset = 1'b1; in_valid = 1'b0; operation = 4'h0; src_a = '0; src_b = '0; out_ready = 1'b0;
    #1;
    chk("reset result", result, 32'h0);
    chk("reset branch", {31'b0, branch_taken}, 32'd0);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      exec($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, i % 3, 1'b0, tbl[i].res, tbl[i].br);

    // Backpressure with ignored in_valid pulses while DONE.
    exec("backpressure", 4'b1100, 32'h1, 32'd31, 10, 1'b1, 32'h8000_0000, 1'b0);

    // Reset in the third SHIFT cycle discards the op.
    in_valid = 1'b1; operation = 4'b1011; src_a = 32'hFFFF_FFFF; src_b = 32'd20;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("midshift busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("midshift busy3", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midshift rst result", result, 32'h0);
    chk("midshift rst branch", {31'b0, branch_taken}, 32'd0);
    chk("midshift rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midshift rst busy", {31'b0, busy}, 32'd0);
    chk("midshift rst in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    exec("post_reset jalr", 4'b1101, 32'h1001, 32'h10, 0, 1'b0, 32'h0000_1010, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      m   = model(rop, ra, rb);
      exec($sformatf("rand%0d op%b", i, rop), rop, ra, rb, int'($urandom_range(0, 3)), 1'b0,
           m[31:0], m[32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_seq.md
Name: alu_exec_seq

Overview:
- Sequential execution unit that consumes the 4-bit Operation code produced by the ALU controller, plus two operands.
- Produces a registered result and a branch-taken flag for the datapath.
- Shifts are performed iteratively, one bit per cycle. All other operations complete in one cycle.
- Valid/ready handshakes on input and output let the multi-cycle pipeline stall around it.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and operation are presented.
- in_ready  output  1  unit can accept an operation this cycle.
- operation  input  4  Operation code from the ALU controller.
- src_a  input  WIDTH  operand A (rs1 or PC).
- src_b  input  WIDTH  operand B (rs2 or immediate); bits [SHAMT_W-1:0] are the shift amount.
- out_valid  output  1  result and branch_taken are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  registered result.
- branch_taken  output  1  registered branch condition.
- busy  output  1  high in SHIFT state.

Behaviour:
- Operation encoding (fixed, matches the controller):
  - 0000 AND; 0001 OR; 0010 XOR; 0011 ADD; 1001 SUB.
  - 0111 SLT (signed): result = {0…, A<B}.
  - 1100 SLL; 1011 SRL; 1010 SRA.
  - 1000 BEQ; 0100 BNE; 0101 BLT (signed); 0110 BGE (signed).
  - 1101 JALR: result = (A+B) & ~1.
  - 1110 and 1111 are unused: result 0, branch_taken 0.
- Branch ops drive result=0 and branch_taken=condition. All non-branch ops drive branch_taken=0.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept occurs when in_valid && in_ready. Operands and operation are captured on that edge; inputs are ignored in all other cycles.
- IDLE transitions on accept:
  - Non-shift op, or shift op with shamt=0: compute combinationally, register result, go DONE. out_valid rises 1 cycle after the accept edge.
  - Shift op with shamt>0: load accumulator=A and count=shamt, go SHIFT.
- SHIFT, each cycle:
  - Shift the accumulator by 1. SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB.
  - Decrement count.
  - When count reaches 0, go DONE with result=accumulator.
  - Total: out_valid rises shamt+1 cycles after the accept edge.
- DONE:
  - Hold result and branch_taken stable while out_ready=0.
  - On out_ready=1, complete the handshake and go IDLE next cycle.
  - Peak throughput: one operation per 2 cycles.
- result and branch_taken keep their last value in IDLE; consumers qualify them with out_valid.
- Reset, asserted at any time including mid-SHIFT or in DONE:
  - Forces IDLE immediately.
  - result=0, branch_taken=0, out_valid=0, busy=0, in_ready=1, count=0.
  - Any in-flight operation is discarded.
  - After release, the first rising edge may accept.
- Only src_b[SHAMT_W-1:0] is used for shifts; the upper bits of src_b are ignored.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: each SHIFT cycle shifts by min(4, count) bits and subtracts that amount from count. Latency becomes ceil(shamt/4)+1 cycles; results are identical.
- Undefined: shift is 1 bit per cycle, as in Behaviour.

Test Plan:
- ADD: operation=0011, A=0x0000_0005, B=0xFFFF_FFFF, out_ready=1 → out_valid 1 cycle after accept; result=0x0000_0004; branch_taken=0; in_ready back high the following cycle.
- SRA: operation=1010, A=0x8000_0000, B=4 → busy for 4 cycles; out_valid 5 cycles after accept; result=0xF800_0000. With ALU_FAST_SHIFT_EN: out_valid at 2 cycles, same result.
- Branches:
  - BLT, A=0xFFFF_FFFF, B=1 → branch_taken=1, result=0.
  - BGE, same operands → branch_taken=0.
  - BEQ, A=B=7 → branch_taken=1.
- Backpressure: SLL, A=1, B=31, out_ready=0 for 10 cycles after out_valid → result holds 0x8000_0000; in_valid pulses are ignored (in_ready=0); a single handshake completes when out_ready=1.
- Reset mid-shift: SRL, A=0xFFFF_FFFF, B=20, reset asserted in the 3rd SHIFT cycle → all outputs at reset values in the same cycle. Next op JALR, A=0x1001, B=0x10 → result=0x1010.
- Boundaries:
  - SLL with B=0x0000_0020 (shamt=0) → 1-cycle latency, result=A.
  - operation=1111 → result=0, branch_taken=0.
